// File: rtl/fft_out_reorder.sv
// fft_out_reorder
//   Reorder buffer placed after fft_stage2. Bins arrive in bit-reversed order
//   (position given by iaddr); each complete frame is re-emitted in natural
//   bin order 0..N-1 as N contiguous oen cycles. Two banks are used as a
//   ping-pong so back-to-back frames at one sample per cycle flow without gaps.
//
// Parameters
//   TOTAL_STAGE : log2 of the frame length N
//   CPLX_WIDTH  : width of one complex sample {re, im}
//   BITREV      : 1 = store at bitrev(iaddr), 0 = store at iaddr (debug)
//
// Ports
//   iclk   in   clock, rising edge
//   rst_n  in   synchronous active-low reset
//   ien    in   input sample valid
//   iaddr  in   input sample position within frame (iaddr==N-1 ends a frame)
//   idata  in   input complex sample
//   oen    out  output sample valid
//   oaddr  out  natural-order bin index
//   odata  out  output complex sample
//   osof   out  high together with oaddr==0 of each output frame
//   ovf    out  sticky overflow: an input sample arrived with no free bank
module fft_out_reorder #(
  parameter int TOTAL_STAGE = 4,
  parameter int CPLX_WIDTH  = 32,
  parameter bit BITREV      = 1'b1
) (
  input  logic                   iclk,
  input  logic                   rst_n,
  input  logic                   ien,
  input  logic [TOTAL_STAGE-1:0] iaddr,
  input  logic [CPLX_WIDTH-1:0]  idata,
  output logic                   oen,
  output logic [TOTAL_STAGE-1:0] oaddr,
  output logic [CPLX_WIDTH-1:0]  odata,
  output logic                   osof,
  output logic                   ovf
);

  localparam int N = 1 << TOTAL_STAGE;
  localparam logic [TOTAL_STAGE-1:0] LAST_ADDR = {TOTAL_STAGE{1'b1}};

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FULL    = 2'd1,
    BANK_READING = 2'd2
  } bank_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

  // Both banks live in one array; the bank select is the top address bit.
  logic [CPLX_WIDTH-1:0]  mem [0:2*N-1];

  bank_state_t            bank_state_reg [0:1];
  logic                   wr_bank_reg;
  logic                   rd_bank_reg;
  logic [TOTAL_STAGE-1:0] rc_reg;
  rd_state_t              rd_state_reg;

  logic [CPLX_WIDTH-1:0]  ram_q_reg;
  logic                   issue_v_reg;
  logic [TOTAL_STAGE-1:0] issue_rc_reg;

  logic [TOTAL_STAGE-1:0] iaddr_rev;
  logic [TOTAL_STAGE-1:0] wr_addr;
  logic                   wr_accept;
  logic                   wr_drop;
  logic                   rd_issue;
  logic                   rd_other_bank;

  // Bit reversal of the input position.
  genvar gi;
  generate
    for (gi = 0; gi < TOTAL_STAGE; gi++) begin : g_rev
      assign iaddr_rev[gi] = iaddr[TOTAL_STAGE-1-gi];
    end
  endgenerate

  assign wr_addr       = BITREV ? iaddr_rev : iaddr;
  assign wr_accept     = ien && (bank_state_reg[wr_bank_reg] == BANK_FREE);
  assign wr_drop       = ien && (bank_state_reg[wr_bank_reg] != BANK_FREE);
  assign rd_other_bank = ~rd_bank_reg;

  // In IDLE rc_reg is always 0, so an issue from IDLE reads bin 0.
  assign rd_issue = (rd_state_reg == RD_READ) ||
                    (bank_state_reg[rd_bank_reg] == BANK_FULL);

  // Writer, reader FSM and bank status. Writer only moves FREE->FULL and the
  // reader only moves FULL->READING->FREE, so both sides never update the same
  // bank in one cycle; status changes become visible the following cycle.
  always_ff @(posedge iclk) begin
    if (!rst_n) begin
      bank_state_reg[0] <= BANK_FREE;
      bank_state_reg[1] <= BANK_FREE;
      wr_bank_reg       <= 1'b0;
      rd_bank_reg       <= 1'b0;
      rc_reg            <= '0;
      rd_state_reg      <= RD_IDLE;
      ovf               <= 1'b0;
    end else begin
      // Frame end is defined solely by the position, never by ien gaps.
      if (wr_accept && (iaddr == LAST_ADDR)) begin
        bank_state_reg[wr_bank_reg] <= BANK_FULL;
        wr_bank_reg                 <= ~wr_bank_reg;
      end
      if (wr_drop) begin
        ovf <= 1'b1;
      end

      case (rd_state_reg)
        RD_IDLE: begin
          if (bank_state_reg[rd_bank_reg] == BANK_FULL) begin
            bank_state_reg[rd_bank_reg] <= BANK_READING;
            rc_reg                      <= rc_reg + 1'b1;
            rd_state_reg                <= RD_READ;
          end
        end
        RD_READ: begin
          if (rc_reg == LAST_ADDR) begin
            bank_state_reg[rd_bank_reg] <= BANK_FREE;
            rd_bank_reg                 <= rd_other_bank;
            rc_reg                      <= '0;
            // Chain straight into the other bank when it is ready, so
            // consecutive frames come out without an idle cycle.
            if (bank_state_reg[rd_other_bank] == BANK_FULL) begin
              bank_state_reg[rd_other_bank] <= BANK_READING;
            end else begin
              rd_state_reg <= RD_IDLE;
            end
          end else begin
            rc_reg <= rc_reg + 1'b1;
          end
        end
        default: rd_state_reg <= RD_IDLE;
      endcase
    end
  end

  // Sample storage: one write port, one registered read port.
  always_ff @(posedge iclk) begin
    if (rst_n && wr_accept) begin
      mem[{wr_bank_reg, wr_addr}] <= idata;
    end
  end

  always_ff @(posedge iclk) begin
    if (rd_issue) begin
      ram_q_reg <= mem[{rd_bank_reg, rc_reg}];
    end
  end

  // Read-issue tracking and the output register stage.
  always_ff @(posedge iclk) begin
    if (!rst_n) begin
      issue_v_reg  <= 1'b0;
      issue_rc_reg <= '0;
      oen          <= 1'b0;
      oaddr        <= '0;
      osof         <= 1'b0;
      odata        <= '0;
    end else begin
      issue_v_reg  <= rd_issue;
      issue_rc_reg <= rc_reg;
      oen          <= issue_v_reg;
      osof         <= issue_v_reg && (issue_rc_reg == '0);
      if (issue_v_reg) begin
        oaddr <= issue_rc_reg;
        odata <= ram_q_reg;
      end
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Testbench for fft_out_reorder (N=16, 32-bit samples). Stimulus pushes the
// expected natural-order output into a queue; monitors pop and compare every
// cycle the DUT asserts oen. A second instance with BITREV=0 checks the
// pass-through ordering.
module tb_fft_out_reorder;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
    logic        sof;
  } exp_t;

  logic        iclk;
  logic        rst_n;
  logic        ien;
  logic        ien_nr;
  logic [3:0]  iaddr;
  logic [31:0] idata;

  logic        oen, osof, ovf;
  logic [3:0]  oaddr;
  logic [31:0] odata;

  logic        oen_nr, osof_nr, ovf_nr;
  logic [3:0]  oaddr_nr;
  logic [31:0] odata_nr;

  int tests_run    = 0;
  int tests_failed = 0;

  exp_t exp_q[$];
  exp_t exp_nr_q[$];
  exp_t e_main;
  exp_t e_nr;
  logic in_frame    = 1'b0;
  logic in_frame_nr = 1'b0;

  fft_out_reorder #(.TOTAL_STAGE(4), .CPLX_WIDTH(32), .BITREV(1'b1)) u_dut (
    .iclk  (iclk),
    .rst_n (rst_n),
    .ien   (ien),
    .iaddr (iaddr),
    .idata (idata),
    .oen   (oen),
    .oaddr (oaddr),
    .odata (odata),
    .osof  (osof),
    .ovf   (ovf)
  );

  fft_out_reorder #(.TOTAL_STAGE(4), .CPLX_WIDTH(32), .BITREV(1'b0)) u_dut_nr (
    .iclk  (iclk),
    .rst_n (rst_n),
    .ien   (ien_nr),
    .iaddr (iaddr),
    .idata (idata),
    .oen   (oen_nr),
    .oaddr (oaddr_nr),
    .odata (odata_nr),
    .osof  (osof_nr),
    .ovf   (ovf_nr)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] bitrev4(input logic [3:0] a);
    return {a[0], a[1], a[2], a[3]};
  endfunction

  // Output monitor, BITREV=1 instance.
  always @(negedge iclk) begin
    if (oen) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_out: got oaddr=%0d odata=%h, expected no output", oaddr, odata);
      end else begin
        e_main = exp_q.pop_front();
        check("out_addr", 64'(oaddr), 64'(e_main.addr));
        check("out_data", 64'(odata), 64'(e_main.data));
        check("out_sof",  64'(osof),  64'(e_main.sof));
        $display("[MON] bin %0d data %h sof %0d", oaddr, odata, osof);
      end
      in_frame = (oaddr != 4'd15);
    end else if (in_frame) begin
      if (rst_n) begin
        tests_run++;
        tests_failed++;
        $display("FAIL out_gap: got oen=0 inside a frame, expected 1");
      end
      in_frame = 1'b0;
    end
  end

  // Output monitor, BITREV=0 instance.
  always @(negedge iclk) begin
    if (oen_nr) begin
      if (exp_nr_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_out_nr: got oaddr=%0d odata=%h, expected no output", oaddr_nr, odata_nr);
      end else begin
        e_nr = exp_nr_q.pop_front();
        check("nr_out_addr", 64'(oaddr_nr), 64'(e_nr.addr));
        check("nr_out_data", 64'(odata_nr), 64'(e_nr.data));
        check("nr_out_sof",  64'(osof_nr),  64'(e_nr.sof));
        $display("[MON-NR] bin %0d data %h sof %0d", oaddr_nr, odata_nr, osof_nr);
      end
      in_frame_nr = (oaddr_nr != 4'd15);
    end else if (in_frame_nr) begin
      if (rst_n) begin
        tests_run++;
        tests_failed++;
        $display("FAIL out_gap_nr: got oen=0 inside a frame, expected 1");
      end
      in_frame_nr = 1'b0;
    end
  end

  task automatic drive(input logic en, input logic en_nr, input logic [3:0] a, input logic [31:0] d);
    @(negedge iclk);
    ien    = en;
    ien_nr = en_nr;
    iaddr  = a;
    idata  = d;
  endtask

  task automatic idle();
    @(negedge iclk);
    ien    = 1'b0;
    ien_nr = 1'b0;
  endtask

  // Positions 0..15 in order, data = bitrev(position) + base, so natural bin k
  // must come out as base + k.
  task automatic send_frame(input logic [31:0] base, input bit gapped);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 4'(i), base + 32'(bitrev4(4'(i))));
      if (gapped && i != 15) drive(1'b0, 1'b0, 4'(i), 32'hFFFF_FFFF);
    end
  endtask

  task automatic push_frame(input logic [31:0] base);
    for (int k = 0; k < 16; k++) exp_q.push_back('{addr: 4'(k), data: base + 32'(k), sof: (k == 0)});
  endtask

  // Call right after the negedge that presented iaddr=15.
  task automatic expect_latency(input string name);
    @(negedge iclk);
    ien = 1'b0;
    check({name, "_lat_t1_oen"}, 64'(oen), 64'd0);
    @(negedge iclk);
    check({name, "_lat_t2_oen"}, 64'(oen), 64'd0);
    @(negedge iclk);
    check({name, "_lat_t3_first"}, 64'({oen, osof, oaddr}), 64'({1'b1, 1'b1, 4'd0}));
  endtask

  task automatic measure_run(input int budget, output int len);
    len = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge iclk);
      if (oen) break;
    end
    while (oen && len < 200) begin
      len++;
      @(negedge iclk);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int c = 0; c < budget && (exp_q.size() != 0 || exp_nr_q.size() != 0); c++) @(negedge iclk);
    check({name, "_drain"}, 64'(exp_q.size() + exp_nr_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge iclk);
    rst_n  = 1'b0;
    ien    = 1'b0;
    ien_nr = 1'b0;
    @(negedge iclk);
    @(negedge iclk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit reached");
  end

  initial begin
    int run_len;
    bit found;
    int stray;

    rst_n  = 1'b0;
    ien    = 1'b0;
    ien_nr = 1'b0;
    iaddr  = '0;
    idata  = '0;

    // Reset with random input activity: all outputs stay 0.
    for (int c = 0; c < 3; c++) begin
      @(negedge iclk);
      check("rst_outs",    64'({oen, oaddr, osof, ovf, odata}), 64'd0);
      check("rst_outs_nr", 64'({oen_nr, oaddr_nr, osof_nr, ovf_nr, odata_nr}), 64'd0);
      ien   = 1'($urandom);
      iaddr = 4'($urandom);
      idata = $urandom;
    end
    @(negedge iclk);
    rst_n = 1'b1;
    ien   = 1'b0;
    @(negedge iclk);
    check("post_rst_outs",    64'({oen, oaddr, osof, ovf, odata}), 64'd0);
    check("post_rst_outs_nr", 64'({oen_nr, oaddr_nr, osof_nr, ovf_nr, odata_nr}), 64'd0);

    // Single frame: bin k = 100 + k, first oen 2 cycles after iaddr=15.
    push_frame(32'd100);
    send_frame(32'd100, 1'b0);
    expect_latency("single");
    wait_drain("single", 40);

    // Four back-to-back frames: 64 contiguous output cycles, no overflow.
    push_frame(32'h1234_1000);
    push_frame(32'h1234_2000);
    push_frame(32'h1234_3000);
    push_frame(32'h1234_4000);
    fork
      begin
        send_frame(32'h1234_1000, 1'b0);
        send_frame(32'h1234_2000, 1'b0);
        send_frame(32'h1234_3000, 1'b0);
        send_frame(32'h1234_4000, 1'b0);
        idle();
      end
      measure_run(60, run_len);
    join
    check("b2b_run_len", 64'(run_len), 64'd64);
    check("b2b_ovf", 64'(ovf), 64'd0);
    wait_drain("b2b", 40);

    // Gapped input: still 16 contiguous outputs.
    push_frame(32'h0000_5000);
    fork
      begin
        send_frame(32'h0000_5000, 1'b1);
        idle();
      end
      measure_run(60, run_len);
    join
    check("gap_run_len", 64'(run_len), 64'd16);
    wait_drain("gap", 40);

    // Overflow. Fill bank0/bank1 with known data first so that a one-sample
    // frame 2 (iaddr=15 only) has known contents in every other bin.
    do_reset();
    push_frame(32'h0000_6000);
    push_frame(32'h0000_7000);
    fork
      begin
        send_frame(32'h0000_6000, 1'b0);
        send_frame(32'h0000_7000, 1'b0);
        idle();
      end
      measure_run(60, run_len);
    join
    check("ovf_prep_run_len", 64'(run_len), 64'd32);
    wait_drain("ovf_prep", 40);

    push_frame(32'h0000_8000);
    for (int k = 0; k < 16; k++)
      exp_q.push_back('{addr: 4'(k), data: (k == 15) ? 32'h0000_900F : 32'h0000_7000 + 32'(k), sof: (k == 0)});
    send_frame(32'h0000_8000, 1'b0);
    drive(1'b1, 1'b0, 4'd15, 32'h0000_900F);
    drive(1'b1, 1'b0, 4'd0, 32'hDEAD_0000);
    check("ovf_before_drop", 64'(ovf), 64'd0);
    drive(1'b1, 1'b0, 4'd1, 32'hDEAD_0001);
    check("ovf_rise", 64'(ovf), 64'd1);
    drive(1'b1, 1'b0, 4'd2, 32'hDEAD_0002);
    drive(1'b1, 1'b0, 4'd3, 32'hDEAD_0003);
    idle();
    wait_drain("ovf", 60);
    check("ovf_sticky", 64'(ovf), 64'd1);

    // Mid-frame reset at output sample 7.
    for (int k = 0; k < 8; k++) exp_q.push_back('{addr: 4'(k), data: 32'h0000_A000 + 32'(k), sof: (k == 0)});
    send_frame(32'h0000_A000, 1'b0);
    idle();
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge iclk);
      if (oen && oaddr == 4'd7) begin
        found = 1'b1;
        break;
      end
    end
    check("midrst_reached_bin7", 64'(found), 64'd1);
    rst_n = 1'b0;
    @(negedge iclk);
    check("midrst_oen", 64'(oen), 64'd0);
    check("midrst_ovf_clear", 64'(ovf), 64'd0);
    check("midrst_q_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge iclk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge iclk);
      if (oen) stray++;
    end
    check("midrst_no_more_out", 64'(stray), 64'd0);
    push_frame(32'h0000_B000);
    send_frame(32'h0000_B000, 1'b0);
    expect_latency("fresh");
    wait_drain("fresh", 40);

    // BITREV=0: output order equals input data order.
    for (int k = 0; k < 16; k++)
      exp_nr_q.push_back('{addr: 4'(k), data: 32'h0000_C000 + 32'(3 * k), sof: (k == 0)});
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 4'(i), 32'h0000_C000 + 32'(3 * i));
    idle();
    wait_drain("nr", 40);
    check("nr_ovf", 64'(ovf_nr), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Output reorder buffer that sits directly downstream of `fft_stage2`. It consumes that stage's `oen`/`oaddr`/`odata` stream, in which bins arrive in bit-reversed order. It re-emits each complete frame in natural bin order (0..N-1) on an identical `oen`/`oaddr`/`odata` interface. Buffering is a two-bank ping-pong, so continuous back-to-back frames at one sample per cycle pass with no gaps.

## Interface
Widths come from `fft_inc.h`: `TOTAL_STAGE` (log2 N) and `CPLX_WIDTH`. N = 2^`TOTAL_STAGE`.

Parameters:
- `BITREV`, default 1. 1 = write address is bit-reverse(`iaddr`). 0 = write address is `iaddr` (pass-through ordering, for debug).

Ports:
- `iclk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ien`  in  1  input sample valid.
- `iaddr`  in  `TOTAL_STAGE`  input sample position within frame.
- `idata`  in  `CPLX_WIDTH`  input complex sample {re, im}.
- `oen`  out  1  output sample valid.
- `oaddr`  out  `TOTAL_STAGE`  natural-order bin index.
- `odata`  out  `CPLX_WIDTH`  output complex sample.
- `osof`  out  1  high with `oaddr`==0 of each output frame.
- `ovf`  out  1  sticky overflow flag.

## Operation
- Storage: two banks, each N x `CPLX_WIDTH`, with synchronous read. Per-bank status is 2 bits: FREE, FULL, READING.
- Writer: holds `wr_bank` (reset 0).
  - On `ien`=1 with `wr_bank` FREE: write `idata` at wa = `BITREV` ? bitrev(`iaddr`) : `iaddr`.
  - When a write has `iaddr`==N-1: mark `wr_bank` FULL and toggle `wr_bank`. This is the frame end. Frame boundaries come only from `iaddr`==N-1, never from `ien` gaps.
  - On `ien`=1 with `wr_bank` not FREE: drop the sample and set `ovf`=1. `ovf` stays set until reset.
- Reader FSM: `rd_bank` (reset 0), counter `rc` of `TOTAL_STAGE` bits.
  - IDLE: if bank[`rd_bank`] is FULL, mark it READING, issue read at `rc`=0, go to READ.
  - READ: issue one read per cycle, `rc` incrementing.
  - At `rc`=N-1: mark bank FREE, toggle `rd_bank`, and wrap `rc` to 0.
    - If the new `rd_bank` is already FULL, mark it READING and stay in READ with no bubble.
    - Otherwise go to IDLE.
- Output register: `oen`, `oaddr`, `osof`, `odata` are registered one cycle after read issue. `oaddr` is `rc` delayed one cycle. `osof` = issued `rc`==0.
- The writer and reader never access the same bank in the same cycle.
- Simultaneous events resolve as follows:
  - A bank freed by the reader in cycle t is writable in cycle t+1, not t.
  - A FULL mark in cycle t is visible to the reader in cycle t+1.
- Reset: clears all status to FREE, `wr_bank`=`rd_bank`=0, `rc`=0, FSM to IDLE, and all outputs to 0 (`oen`, `oaddr`, `odata`, `osof`, `ovf`). A partially written or partially read frame is discarded. RAM contents are not cleared.
- Gaps in `ien` are allowed mid-frame. The output of a frame is always N contiguous `oen` cycles.

## Timing
- Latency: last input sample (`iaddr`=N-1) sampled at edge T gives bank FULL after T. The reader issues at edge T+1. The first `oen` with `oaddr`=0 is visible after edge T+2, i.e. 2 cycles after the last input.
- Throughput: 1 sample/cycle sustained. With continuous input, frame k+1 output follows frame k output with zero idle cycles.
- Overflow arises only when a third frame starts before the reader has freed a bank. At 1 sample/cycle continuous input this never occurs.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with random `ien`. All outputs are 0 during reset and on the cycle after release.
- Single frame, N=16 (`TOTAL_STAGE`=4): drive `iaddr`=0..15 on consecutive cycles with data = bitrev(`iaddr`)+100. Output is `oaddr`=0..15 with `odata`=100..115, `osof` on the first cycle, and the first `oen` 2 cycles after `iaddr`=15.
- Back-to-back: 4 continuous frames with distinct data. 64 contiguous `oen` cycles, each frame in natural order, `ovf`=0.
- Gapped input: `ien` toggles 1/0 within a frame. Output is still 16 contiguous samples, correct values.
- Overflow: 3 frames input while the reader is blocked by a forced stall (frames 1 and 2 FULL). The first sample of frame 3 is dropped and `ovf` rises the next cycle and stays 1. Frames 1 and 2 still output correctly.
- Mid-frame reset: assert `rst_n`=0 at output sample 7. `oen`=0 next cycle, nothing more is emitted, and the next fresh frame outputs correctly after the standard 2-cycle latency. `BITREV`=0 run: output order equals input data order.
